qeciphy_traffic_gen_chk: RTL and testbench
==========================================

Name: qeciphy_traffic_gen_chk

Overview:
Parametrised AXI-Stream traffic generator and self-synchronising checker for QECIPHY link bring-up and soak tests. It drives the QECIPHY TX stream with a selectable pattern (counter, PRBS-31, walking-one) and checks the RX stream against the same pattern. The checker uses a hunt/lock state machine and saturating error and word counters. It sits between a board-level wrapper (VIO/ILA/LEDs) and QECIPHY in the ACLK domain.

Parameters:
DATA_W, 64, stream data width; legal range 32..256.
ERR_CNT_W, 16, width of the saturating error counter.
WORD_CNT_W, 32, width of the saturating TX/RX word counters.
LOCK_CNT, 8, number of consecutive matching RX beats in HUNT required to declare lock (1..255).

Ports:
ACLK  in  1  stream clock.
rst_n  in  1  asynchronous active-low reset.
enable  in  1  generator enable.
mode  in  2  pattern select: 0 counter, 1 PRBS-31, 2 walking-one, 3 treated as counter.
clear  in  1  synchronous single-cycle clear of the counters and the sticky error flag.
TX_TDATA  out  DATA_W  generated data.
TX_TVALID  out  1  generated data valid.
TX_TREADY  in  1  QECIPHY TX ready.
RX_TDATA  in  DATA_W  received data.
RX_TVALID  in  1  received data valid.
RX_TREADY  out  1  tied high.
locked  out  1  checker in LOCKED state.
err_sticky  out  1  set by any counted mismatch.
err_cnt  out  ERR_CNT_W  counted mismatches.
tx_words  out  WORD_CNT_W  accepted TX beats.
rx_words  out  WORD_CNT_W  received RX beats.

Behaviour:
- Reset values:
  - TX_TVALID=0, TX_TDATA=first pattern word of mode 0 (0).
  - locked=0, err_sticky=0, err_cnt=0, tx_words=0, rx_words=0.
  - Checker in IDLE. Latched mode=0.
- Mode latching: the latched mode loads from `mode` only while the generator is idle (TX_TVALID=0). The generator pattern state resets to the mode's first word on that load.
- First words per mode:
  - counter: 0.
  - PRBS-31: the first DATA_W bits from LFSR seed 31'h7FFFFFFF.
  - walking-one: 1.
- Generator:
  - TX_TVALID rises the cycle after enable=1 is seen.
  - TX_TDATA advances only on TX_TVALID && TX_TREADY. It is held stable otherwise (AXI rule).
  - Deasserting enable drops TX_TVALID only after the pending beat handshakes. The drop happens in the same cycle as the handshake when enable=0 at that edge.
- Pattern next-word rules:
  - counter: word+1 mod 2^DATA_W.
  - walking-one: rotate left by 1.
  - PRBS-31: LFSR s[30:0]; each step computes b=s[30]^s[27], then s={s[29:0],b}. A word is DATA_W steps; word bit i is the i-th generated bit.
- Checker FSM:
  - IDLE -> HUNT on the first RX_TVALID beat.
  - HUNT: every beat reseeds the reference from RX_TDATA and compares it against the current reference.
    - match increments the consecutive-match count; mismatch zeroes it.
    - on reaching LOCK_CNT -> LOCKED; locked=1 from the next cycle.
  - LOCKED: on a match, the reference advances.
    - On a mismatch: err_cnt+1 (saturating at all-ones), err_sticky=1.
    - The reference reseeds from RX_TDATA, and the state returns to HUNT (locked=0 next cycle).
  - Mismatches in HUNT are never counted.
- Reseed rules:
  - counter: ref=rx+1.
  - walking-one: ref=rotl(rx).
  - PRBS-31: s[k]=rx[DATA_W-1-k] for k=0..30, then advance one word.
- Counters:
  - tx_words increments on each TX handshake; rx_words increments on each RX_TVALID beat.
  - Both saturate at all-ones.
- clear: zeroes err_cnt, err_sticky, tx_words and rx_words next cycle. It takes priority over a simultaneous increment. FSM and lock state are unchanged.
- Mode mismatch: the checker uses the latched mode.
- Reset mid-operation clears everything asynchronously, including a stalled TX beat.

Optional Feature:
QECIPHY_TGC_ERR_INJECT_EN adds input inject_err (1 bit).
- With the macro: a pulse arms a one-shot that flips bit 0 of the next TX beat actually handshaked. The pattern state is unaffected. Pulses while already armed are ignored.
- Without the macro: the port is absent and TX data is always the pure pattern.

Test Plan:
- Counter loopback: mode=0, TX looped to RX, TREADY=1 -> TX_TDATA 0,1,2,…; locked=1 after 8 beats; err_cnt=0 after 1000 beats; tx_words=rx_words=1000.
- Back-pressure: TREADY toggled at random with enable=1 -> TX_TDATA is held while stalled; no skipped or repeated values; checker stays locked.
- PRBS self-sync: mode=1; RX fed from generator but starting mid-stream at word 57 -> lock after 8 beats; err_cnt=0.
- Single error: locked counter stream; RX word 100 replaced by 0xDEAD -> err_cnt=1, err_sticky=1, locked drops, relocks 8 beats later; a second error is not counted during HUNT.
- Saturation and clear: ERR_CNT_W=2, 5 separate errors each after relock -> err_cnt=3; clear -> err_cnt=0, err_sticky=0 next cycle.
- Disable and mode change: enable=0 while TREADY=0 -> TVALID holds until handshake, then 0; switch mode to 2, enable=1 -> TX_TDATA 1,2,4,…

Source files
------------

// File: rtl/qeciphy_traffic_gen_chk.sv
// AXI-Stream pattern generator (counter / PRBS-31 / walking-one) with a self-synchronising checker.
// Optional `define QECIPHY_TGC_ERR_INJECT_EN adds inject_err: one-shot flip of bit 0 on a TX beat.
module qeciphy_traffic_gen_chk #(
    parameter int DATA_W     = 64,
    parameter int ERR_CNT_W  = 16,
    parameter int WORD_CNT_W = 32,
    parameter int LOCK_CNT   = 8
) (
    input  logic                  ACLK,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic                  clear,
`ifdef QECIPHY_TGC_ERR_INJECT_EN
    input  logic                  inject_err,
`endif
    output logic [DATA_W-1:0]     TX_TDATA,
    output logic                  TX_TVALID,
    input  logic                  TX_TREADY,
    input  logic [DATA_W-1:0]     RX_TDATA,
    input  logic                  RX_TVALID,
    output logic                  RX_TREADY,
    output logic                  locked,
    output logic                  err_sticky,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic [WORD_CNT_W-1:0] tx_words,
    output logic [WORD_CNT_W-1:0] rx_words
);

    // Word bit i is the i-th bit produced by the LFSR, starting from state s.
    function automatic logic [DATA_W-1:0] prbs_word(input logic [30:0] s);
        logic [30:0] st;
        logic        b;
        st        = s;
        prbs_word = '0;
        for (int i = 0; i < DATA_W; i++) begin
            b            = st[30] ^ st[27];
            prbs_word[i] = b;
            st           = {st[29:0], b};
        end
    endfunction

    function automatic logic [30:0] prbs_adv(input logic [30:0] s);
        logic [30:0] st;
        st = s;
        for (int i = 0; i < DATA_W; i++) begin
            st = {st[29:0], st[30] ^ st[27]};
        end
        return st;
    endfunction

    function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] w);
        return {w[DATA_W-2:0], w[DATA_W-1]};
    endfunction

    localparam logic [1:0]        MODE_PRBS = 2'd1;
    localparam logic [1:0]        MODE_WALK = 2'd2;
    localparam logic [30:0]       PRBS_SEED = 31'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] PRBS_W0   = prbs_word(PRBS_SEED);
    localparam logic [30:0]       PRBS_S1   = prbs_adv(PRBS_SEED);

    // ---------------- generator ----------------
    logic                tx_valid_q;
    logic [DATA_W-1:0]   gen_data_q, gen_data_d, first_data;
    logic [30:0]         gen_lfsr_q, gen_lfsr_d;
    logic [1:0]          mode_q;
    logic                tx_hs;

    assign tx_hs = tx_valid_q & TX_TREADY;

    always_comb begin
        first_data = '0;
        if (mode == MODE_PRBS) begin
            first_data = PRBS_W0;
        end else if (mode == MODE_WALK) begin
            first_data = DATA_W'(1);
        end
    end

    always_comb begin
        gen_data_d = gen_data_q + DATA_W'(1);
        gen_lfsr_d = gen_lfsr_q;
        if (mode_q == MODE_PRBS) begin
            gen_data_d = prbs_word(gen_lfsr_q);
            gen_lfsr_d = prbs_adv(gen_lfsr_q);
        end else if (mode_q == MODE_WALK) begin
            gen_data_d = rotl1(gen_data_q);
        end
    end

    // While idle the mode is re-latched and the pattern rewinds every cycle, so a new
    // burst always starts from the first word of whatever mode is selected.
    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid_q <= 1'b0;
            gen_data_q <= '0;
            gen_lfsr_q <= PRBS_S1;
            mode_q     <= 2'd0;
        end else if (!tx_valid_q) begin
            mode_q     <= mode;
            gen_data_q <= first_data;
            gen_lfsr_q <= PRBS_S1;
            tx_valid_q <= enable;
        end else if (TX_TREADY) begin
            gen_data_q <= gen_data_d;
            gen_lfsr_q <= gen_lfsr_d;
            tx_valid_q <= enable;
        end
    end

`ifdef QECIPHY_TGC_ERR_INJECT_EN
    logic inj_arm_q, inj_flip_q, tx_load;

    // The flip bit only changes when a new beat is loaded, keeping TX_TDATA stable under stall.
    assign tx_load = enable & (~tx_valid_q | TX_TREADY);

    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            inj_arm_q  <= 1'b0;
            inj_flip_q <= 1'b0;
        end else begin
            if (tx_hs && inj_flip_q) begin
                inj_arm_q <= 1'b0;
            end else if (inject_err) begin
                inj_arm_q <= 1'b1;
            end
            if (tx_load) begin
                inj_flip_q <= inj_arm_q & ~(tx_hs & inj_flip_q);
            end else if (~tx_valid_q | tx_hs) begin
                inj_flip_q <= 1'b0;
            end
        end
    end

    assign TX_TDATA = gen_data_q ^ {{(DATA_W-1){1'b0}}, inj_flip_q};
`else
    assign TX_TDATA = gen_data_q;
`endif

    assign TX_TVALID = tx_valid_q;
    assign RX_TREADY = 1'b1;

    // ---------------- checker ----------------
    typedef enum logic [1:0] {ST_IDLE, ST_HUNT, ST_LOCKED} chk_state_e;

    chk_state_e          state_q;
    logic [DATA_W-1:0]   ref_q, ref_adv_d, ref_seed_d;
    logic [30:0]         chk_lfsr_q, lfsr_adv_d, lfsr_seed_d, rx_rev;
    logic [7:0]          match_cnt_q;
    logic                locked_q, rx_match, err_hit;

    // The most recent received bit sits in LFSR position 0.
    for (genvar gi = 0; gi < 31; gi++) begin : g_rx_rev
        assign rx_rev[gi] = RX_TDATA[DATA_W-1-gi];
    end

    assign rx_match = (RX_TDATA == ref_q);
    assign err_hit  = RX_TVALID & (state_q == ST_LOCKED) & ~rx_match;

    always_comb begin
        ref_adv_d   = ref_q + DATA_W'(1);
        lfsr_adv_d  = chk_lfsr_q;
        ref_seed_d  = RX_TDATA + DATA_W'(1);
        lfsr_seed_d = chk_lfsr_q;
        if (mode_q == MODE_PRBS) begin
            ref_adv_d   = prbs_word(chk_lfsr_q);
            lfsr_adv_d  = prbs_adv(chk_lfsr_q);
            ref_seed_d  = prbs_word(rx_rev);
            lfsr_seed_d = prbs_adv(rx_rev);
        end else if (mode_q == MODE_WALK) begin
            ref_adv_d  = rotl1(ref_q);
            ref_seed_d = rotl1(RX_TDATA);
        end
    end

    // The first beat out of IDLE only seeds the reference; LOCK_CNT matches follow before lock.
    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ref_q       <= '0;
            chk_lfsr_q  <= PRBS_S1;
            match_cnt_q <= 8'd0;
            locked_q    <= 1'b0;
        end else if (RX_TVALID) begin
            case (state_q)
                ST_IDLE: begin
                    ref_q       <= ref_seed_d;
                    chk_lfsr_q  <= lfsr_seed_d;
                    match_cnt_q <= 8'd0;
                    state_q     <= ST_HUNT;
                end
                ST_HUNT: begin
                    ref_q      <= ref_seed_d;
                    chk_lfsr_q <= lfsr_seed_d;
                    if (!rx_match) begin
                        match_cnt_q <= 8'd0;
                    end else if (match_cnt_q == 8'(LOCK_CNT - 1)) begin
                        match_cnt_q <= 8'd0;
                        state_q     <= ST_LOCKED;
                        locked_q    <= 1'b1;
                    end else begin
                        match_cnt_q <= match_cnt_q + 8'd1;
                    end
                end
                ST_LOCKED: begin
                    if (rx_match) begin
                        ref_q      <= ref_adv_d;
                        chk_lfsr_q <= lfsr_adv_d;
                    end else begin
                        ref_q       <= ref_seed_d;
                        chk_lfsr_q  <= lfsr_seed_d;
                        match_cnt_q <= 8'd0;
                        state_q     <= ST_HUNT;
                        locked_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- counters ----------------
    logic [ERR_CNT_W-1:0]  err_cnt_q;
    logic                  err_sticky_q;
    logic [WORD_CNT_W-1:0] tx_words_q, rx_words_q;

    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
            tx_words_q   <= '0;
            rx_words_q   <= '0;
        end else if (clear) begin
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
            tx_words_q   <= '0;
            rx_words_q   <= '0;
        end else begin
            if (err_hit) begin
                err_sticky_q <= 1'b1;
                if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end
            if (tx_hs && tx_words_q != '1) tx_words_q <= tx_words_q + WORD_CNT_W'(1);
            if (RX_TVALID && rx_words_q != '1) rx_words_q <= rx_words_q + WORD_CNT_W'(1);
        end
    end

    assign locked     = locked_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;
    assign tx_words   = tx_words_q;
    assign rx_words   = rx_words_q;

endmodule

// File: tb/tb_qeciphy_traffic_gen_chk.sv
// Directed bench for qeciphy_traffic_gen_chk: TX looped into RX with optional word corruption and gating.
module tb_qeciphy_traffic_gen_chk;
    localparam int DW         = 64;
    localparam int EW         = 2;
    localparam int WW         = 10;
    localparam int LC         = 8;
    localparam int PRBS_WORDS = 130;

    logic           ACLK      = 1'b0;
    logic           rst_n     = 1'b1;
    logic           enable    = 1'b0;
    logic [1:0]     mode      = 2'd0;
    logic           clear     = 1'b0;
    logic           TX_TREADY = 1'b0;
    logic [DW-1:0]  TX_TDATA, RX_TDATA;
    logic           TX_TVALID, RX_TVALID, RX_TREADY, locked, err_sticky;
    logic [EW-1:0]  err_cnt;
    logic [WW-1:0]  tx_words, rx_words;

    logic           rx_gate     = 1'b1;
    logic           corrupt     = 1'b0;
    logic [DW-1:0]  corrupt_val = 64'hDEAD;
    logic           g_bits [0:PRBS_WORDS*DW-1];

    int n_total = 0;
    int n_bad   = 0;

    assign RX_TDATA  = corrupt ? corrupt_val : TX_TDATA;
    assign RX_TVALID = TX_TVALID & TX_TREADY & rx_gate;

    qeciphy_traffic_gen_chk #(
        .DATA_W(DW), .ERR_CNT_W(EW), .WORD_CNT_W(WW), .LOCK_CNT(LC)
    ) dut (
        .ACLK(ACLK), .rst_n(rst_n), .enable(enable), .mode(mode), .clear(clear),
        .TX_TDATA(TX_TDATA), .TX_TVALID(TX_TVALID), .TX_TREADY(TX_TREADY),
        .RX_TDATA(RX_TDATA), .RX_TVALID(RX_TVALID), .RX_TREADY(RX_TREADY),
        .locked(locked), .err_sticky(err_sticky), .err_cnt(err_cnt),
        .tx_words(tx_words), .rx_words(rx_words)
    );

    always #5 ACLK = ~ACLK;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge ACLK);
    endtask

    function automatic logic [63:0] prbs_ref(input int n);
        logic [63:0] w;
        w = '0;
        for (int b = 0; b < DW; b++) w[b] = g_bits[n*DW + b];
        return w;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time budget expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_w;
        logic [63:0] walk_w;
        logic        a, c;
        int          hs_cnt;
        int          rdy;

        // PRBS-31 bit stream from the recurrence g[i] = g[i-31] ^ g[i-28], all-ones history.
        for (int i = 0; i < PRBS_WORDS*DW; i++) begin
            if (i < 31) a = 1'b1; else a = g_bits[i-31];
            if (i < 28) c = 1'b1; else c = g_bits[i-28];
            g_bits[i] = a ^ c;
        end

        #2 rst_n = 1'b0;
        tick(); tick();
        $display("phase: reset values");
        check_val("rst_tvalid",  64'(TX_TVALID),  64'd0);
        check_val("rst_tdata",   TX_TDATA,        64'd0);
        check_val("rst_locked",  64'(locked),     64'd0);
        check_val("rst_sticky",  64'(err_sticky), 64'd0);
        check_val("rst_errcnt",  64'(err_cnt),    64'd0);
        check_val("rst_txw",     64'(tx_words),   64'd0);
        check_val("rst_rxw",     64'(rx_words),   64'd0);
        check_val("rst_rxready", 64'(RX_TREADY),  64'd1);
        rst_n = 1'b1;
        tick();

        $display("phase: counter loopback");
        mode = 2'd0; TX_TREADY = 1'b1; enable = 1'b1;
        tick();
        exp_w = 64'd0;
        for (int i = 0; i < 1100; i++) begin
            check_val("cnt_data", TX_TDATA, exp_w);
            if (i == 8) check_val("cnt_lock8", 64'(locked), 64'd0);
            if (i == 9) check_val("cnt_lock9", 64'(locked), 64'd1);
            if (i == 1000) begin
                check_val("cnt_txw1000", 64'(tx_words), 64'd1000);
                check_val("cnt_rxw1000", 64'(rx_words), 64'd1000);
                check_val("cnt_err",     64'(err_cnt),  64'd0);
            end
            tick();
            exp_w = exp_w + 64'd1;
        end
        check_val("sat_txw", 64'(tx_words), 64'd1023);
        check_val("sat_rxw", 64'(rx_words), 64'd1023);

        $display("phase: clear vs simultaneous increment");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_w = exp_w + 64'd1;
        check_val("clr_txw",    64'(tx_words), 64'd0);
        check_val("clr_rxw",    64'(rx_words), 64'd0);
        check_val("clr_locked", 64'(locked),   64'd1);
        check_val("clr_data",   TX_TDATA,      exp_w);
        tick();
        exp_w = exp_w + 64'd1;
        check_val("clr_txw1", 64'(tx_words), 64'd1);
        hs_cnt = 1;

        $display("phase: back-pressure");
        for (int i = 0; i < 200; i++) begin
            check_val("bp_valid", 64'(TX_TVALID), 64'd1);
            check_val("bp_data",  TX_TDATA,       exp_w);
            rdy = $urandom_range(0, 1);
            TX_TREADY = (rdy != 0);
            tick();
            if (rdy != 0) begin
                exp_w  = exp_w + 64'd1;
                hs_cnt = hs_cnt + 1;
            end
        end
        TX_TREADY = 1'b1;
        check_val("bp_data_end", TX_TDATA,       exp_w);
        check_val("bp_locked",   64'(locked),    64'd1);
        check_val("bp_err",      64'(err_cnt),   64'd0);
        check_val("bp_txw",      64'(tx_words),  64'(hs_cnt));
        check_val("bp_rxw",      64'(rx_words),  64'(hs_cnt));
        tick();
        exp_w = exp_w + 64'd1;

        $display("phase: single error then error during hunt");
        for (int j = 0; j < 16; j++) begin
            check_val("se_data", TX_TDATA, exp_w);
            if (j == 1) begin
                check_val("se_err1",    64'(err_cnt),    64'd1);
                check_val("se_sticky",  64'(err_sticky), 64'd1);
                check_val("se_lockoff", 64'(locked),     64'd0);
            end
            if (j == 4)  check_val("se_hunt_nocount", 64'(err_cnt), 64'd1);
            if (j == 12) check_val("se_relock12",     64'(locked),  64'd0);
            if (j == 13) check_val("se_relock13",     64'(locked),  64'd1);
            corrupt = (j == 0 || j == 3);
            tick();
            exp_w = exp_w + 64'd1;
        end
        corrupt = 1'b0;

        $display("phase: error counter saturation");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_w = exp_w + 64'd1;
        check_val("sat_clr_err",    64'(err_cnt),    64'd0);
        check_val("sat_clr_sticky", 64'(err_sticky), 64'd0);
        for (int k = 1; k <= 5; k++) begin
            corrupt = 1'b1;
            tick();
            corrupt = 1'b0;
            exp_w = exp_w + 64'd1;
            for (int j = 0; j < 12; j++) begin
                tick();
                exp_w = exp_w + 64'd1;
            end
            check_val("sat_errcnt", 64'(err_cnt),    (k < 3) ? 64'(k) : 64'd3);
            check_val("sat_sticky", 64'(err_sticky), 64'd1);
            check_val("sat_relock", 64'(locked),     64'd1);
        end
        check_val("sat_data", TX_TDATA, exp_w);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_w = exp_w + 64'd1;
        check_val("sat_clr2_err",    64'(err_cnt),    64'd0);
        check_val("sat_clr2_sticky", 64'(err_sticky), 64'd0);
        check_val("sat_clr2_locked", 64'(locked),     64'd1);

        $display("phase: disable under stall, switch to walking-one");
        TX_TREADY = 1'b0; enable = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            check_val("dis_hold_valid", 64'(TX_TVALID), 64'd1);
            check_val("dis_hold_data",  TX_TDATA,       exp_w);
        end
        TX_TREADY = 1'b1;
        tick();
        check_val("dis_drop", 64'(TX_TVALID), 64'd0);
        tick();
        check_val("dis_idle", 64'(TX_TVALID), 64'd0);
        mode = 2'd2; enable = 1'b1;
        tick();
        walk_w = 64'd1;
        for (int i = 0; i < 70; i++) begin
            check_val("walk_data", TX_TDATA, walk_w);
            if (i == 1) check_val("walk_modeswitch_err", 64'(err_cnt), 64'd1);
            if (i == 8) check_val("walk_lock8", 64'(locked), 64'd0);
            if (i == 9) check_val("walk_lock9", 64'(locked), 64'd1);
            tick();
            walk_w = {walk_w[62:0], walk_w[63]};
        end
        check_val("walk_err_end", 64'(err_cnt), 64'd1);

        $display("phase: reset during stalled beat");
        TX_TREADY = 1'b0;
        tick();
        check_val("mr_stalled", 64'(TX_TVALID), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("mr_tvalid", 64'(TX_TVALID), 64'd0);
        check_val("mr_tdata",  TX_TDATA,       64'd0);
        check_val("mr_locked", 64'(locked),    64'd0);
        check_val("mr_err",    64'(err_cnt),   64'd0);
        check_val("mr_txw",    64'(tx_words),  64'd0);
        tick(); tick();
        enable = 1'b0;
        rst_n  = 1'b1;
        tick();

        $display("phase: PRBS-31 mid-stream self-sync");
        rx_gate = 1'b0; mode = 2'd1; enable = 1'b1; TX_TREADY = 1'b1;
        tick();
        check_val("prbs_word0", TX_TDATA, 64'h3F00_0000_7000_0000);
        for (int i = 0; i < 120; i++) begin
            check_val("prbs_data", TX_TDATA, prbs_ref(i));
            if (i == 65) check_val("prbs_lock65", 64'(locked), 64'd0);
            if (i == 66) check_val("prbs_lock66", 64'(locked), 64'd1);
            rx_gate = (i >= 57);
            tick();
        end
        check_val("prbs_err", 64'(err_cnt),    64'd0);
        check_val("prbs_sticky", 64'(err_sticky), 64'd0);
        check_val("prbs_rxw", 64'(rx_words),   64'd63);
        check_val("prbs_txw", 64'(tx_words),   64'd120);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
